// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-add cell plus a carry/borrow flop,
// processing one operand bit per clock, LSB first, under a start/busy/done handshake.
module serial_addsub #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         c_out,
  output logic         ovf
);

  localparam int unsigned CW = $clog2(W);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state;
  logic [W-1:0]   a_sr;
  logic [W-1:0]   b_sr;
  logic           cy;
  logic           sub_q;
  logic [CW-1:0]  cnt;

  logic           s;
  logic           cy_next;
  logic           last;

  always_comb begin
    s       = a_sr[0] ^ b_sr[0] ^ cy;
    cy_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & cy) | (b_sr[0] & cy);
    last    = (cnt == CW'(W - 1));
  end

  // Subtract runs as a + ~b + ~borrow_in; the carry out is inverted back into a borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      cy     <= 1'b0;
      sub_q  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      c_out  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            cy    <= c_in ^ sub;
            sub_q <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          result <= {s, result[W-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cy     <= cy_next;
          cnt    <= cnt + 1'b1;
          if (last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            c_out <= cy_next ^ sub_q;
            ovf   <= cy ^ cy_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: W=8 directed vectors plus an exhaustive W=2 sweep.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] res8;

  logic       start2 = 1'b0, sub2 = 1'b0, cin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] res2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [9:0] q8[$];
  logic [3:0] q2[$];

  serial_addsub #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8), .c_in(cin8),
    .busy(busy8), .done(done8), .result(res8), .c_out(cout8), .ovf(ovf8)
  );

  serial_addsub #(.W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2), .c_in(cin2),
    .busy(busy2), .done(done2), .result(res2), .c_out(cout2), .ovf(ovf2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: pop an expectation every time a DUT presents done.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        chk("w8_unexpected_done", 32'(done8), 32'd0);
      end else begin
        logic [9:0] e;
        e = q8.pop_front();
        chk("w8_result", 32'(res8),  32'(e[9:2]));
        chk("w8_c_out",  32'(cout8), 32'(e[1]));
        chk("w8_ovf",    32'(ovf8),  32'(e[0]));
        chk("w8_busy_at_done", 32'(busy8), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done2) begin
      if (q2.size() == 0) begin
        chk("w2_unexpected_done", 32'(done2), 32'd0);
      end else begin
        logic [3:0] e;
        e = q2.pop_front();
        chk("w2_result", 32'(res2),  32'(e[3:2]));
        chk("w2_c_out",  32'(cout2), 32'(e[1]));
        chk("w2_ovf",    32'(ovf2),  32'(e[0]));
      end
    end
  end

  task automatic wait_done8(input int max_cyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done8) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // One W=8 operation; operands are scrambled during RUN to show they are not sampled.
  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic ci,
                     input logic [7:0] er, input logic ec, input logic eo, output int bcyc);
    bit found;
    @(negedge clk);
    start8 = 1'b1; sub8 = s; a8 = a; b8 = b; cin8 = ci;
    q8.push_back({er, ec, eo});
    @(negedge clk);
    start8 = 1'b0;
    bcyc = 0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done8) begin
        found = 1'b1;
        break;
      end
      if (busy8) bcyc++;
      a8 = ~a8; b8 = b8 + 8'h5B; sub8 = ~sub8; cin8 = ~cin8;
      @(negedge clk);
    end
    chk("w8_done_seen", 32'(found), 32'd1);
  endtask

  task automatic op2(input logic s, input logic [1:0] a, input logic [1:0] b, input logic ci);
    int  sa, sb, t, sv;
    logic [1:0] r;
    logic c, o;
    bit found;
    sa = (a >= 2) ? int'(a) - 4 : int'(a);
    sb = (b >= 2) ? int'(b) - 4 : int'(b);
    if (!s) begin
      t  = int'(a) + int'(b) + int'(ci);
      c  = (t > 3);
      sv = sa + sb + int'(ci);
    end else begin
      t  = int'(a) - int'(b) - int'(ci);
      c  = (t < 0);
      sv = sa - sb - int'(ci);
    end
    r = 2'(t & 3);
    o = (sv > 1) || (sv < -2);
    @(negedge clk);
    start2 = 1'b1; sub2 = s; a2 = a; b2 = b; cin2 = ci;
    q2.push_back({r, c, o});
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (done2) begin
        found = 1'b1;
        break;
      end
    end
    chk("w2_done_seen", 32'(found), 32'd1);
  endtask

  initial begin
    int  bc;
    bit  found;
    int  t1, t2;

    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(busy8), 32'd0);
    chk("rst_done",   32'(done8), 32'd0);
    chk("rst_result", 32'(res8),  32'd0);
    chk("rst_c_out",  32'(cout8), 32'd0);
    chk("rst_ovf",    32'(ovf8),  32'd0);
    rst_n = 1'b1;

    op8(1'b0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, bc);
    chk("w8_busy_cycles", 32'(bc), 32'd8);
    op8(1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, bc);
    op8(1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, bc);
    op8(1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b0, bc);
    op8(1'b1, 8'h80, 8'h01, 1'b1, 8'h7E, 1'b0, 1'b1, bc);
    chk("w8_busy_cycles_sub", 32'(bc), 32'd8);

    // start pulsed in the third RUN cycle must be dropped
    @(negedge clk);
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    q8.push_back({8'h30, 1'b0, 1'b0});
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk); start8 = 1'b1; sub8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    wait_done8(20, found);
    chk("ignored_start_done", 32'(found), 32'd1);
    repeat (12) @(negedge clk);
    chk("ignored_start_idle", 32'(busy8), 32'd0);

    // start held high through done: the second op is accepted on the done cycle
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h0A; b8 = 8'h05; cin8 = 1'b0;
    q8.push_back({8'h0F, 1'b0, 1'b0});
    wait_done8(20, found);
    chk("b2b_first_done", 32'(found), 32'd1);
    t1 = cyc;
    sub8 = 1'b1; a8 = 8'h20; b8 = 8'h01; cin8 = 1'b0;
    q8.push_back({8'h1F, 1'b0, 1'b0});
    @(negedge clk);
    start8 = 1'b0;
    chk("b2b_busy_after_done", 32'(busy8), 32'd1);
    wait_done8(20, found);
    chk("b2b_second_done", 32'(found), 32'd1);
    t2 = cyc;
    chk("b2b_spacing", 32'(t2 - t1), 32'd9);

    // reset mid-run aborts with no done pulse
    @(negedge clk);
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h55; b8 = 8'h33; cin8 = 1'b0;
    @(negedge clk); start8 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy",   32'(busy8), 32'd0);
    chk("abort_done",   32'(done8), 32'd0);
    chk("abort_result", 32'(res8),  32'd0);
    chk("abort_c_out",  32'(cout8), 32'd0);
    chk("abort_ovf",    32'(ovf8),  32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("after_abort_done",   32'(done8), 32'd0);
    chk("after_abort_result", 32'(res8),  32'd0);
    op8(1'b0, 8'h55, 8'h33, 1'b0, 8'h88, 1'b0, 1'b1, bc);

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++)
          for (int c = 0; c < 2; c++)
            op2(1'(s), 2'(a), 2'(b), 1'(c));

    repeat (12) @(negedge clk);
    chk("q8_drained", 32'(q8.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
